// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared definitions for the Booth multiplier / product accumulator
//            datapath: default widths, accumulator saturation limits and the
//            accumulator FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Default widths shared with the 8x8 sequential Booth multiplier.
  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;

  // Saturation limits for the default accumulator width.
  localparam logic [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // Accumulator job FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Purpose  : Combinational signed add of a sign-extended IN_W operand onto an
//            ACC_W accumulator value, clamped to the ACC_W signed range.
// Ports    : acc_i [ACC_W] - current accumulator value (signed)
//            add_i [IN_W]  - operand to add (signed, sign-extended)
//            sum_o [ACC_W] - clamped sum (signed)
//            sat_o         - high when the sum was clamped
// Revision : 1.0 - initial release
// ============================================================================
module sat_add
  import booth_pkg::*;
#(
  parameter int IN_W  = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit is enough: ACC_W >= IN_W+1, so the true sum of two in-range
  // values always fits in ACC_W+1 bits.
  logic [ACC_W:0] w_wide;

  always_comb begin
    w_wide = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-IN_W){add_i[IN_W-1]}}, add_i};
    sum_o  = w_wide[ACC_W-1:0];
    sat_o  = 1'b0;
    // Guard bit disagreeing with the ACC_W sign bit means out of range;
    // the guard bit carries the true sign and picks the clamp direction.
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      sat_o = 1'b1;
      sum_o = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_product_acc.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_acc
// Purpose  : Accumulates a programmed number of signed products from the
//            Booth multiplier into a saturating signed sum and presents the
//            result on a valid/ready port.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, len        - begin a job of len products (IDLE only)
//            in_valid/in_ready/in_prod   - product stream
//            out_valid/out_ready/out_sum/out_sat - job result
//            busy              - job in progress or result pending
// Revision : 1.0 - initial release
// ============================================================================
module booth_product_acc
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              busy
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic             sat_q,   sat_d;

  logic [ACC_W-1:0] sum_w;
  logic             sat_w;
  logic             xfer_w;

  sat_add #(
    .IN_W  (PROD_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_i (acc_q),
    .add_i (in_prod),
    .sum_o (sum_w),
    .sat_o (sat_w)
  );

  // Outputs decode directly from registered state, so they are glitch-free.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_sat   = out_valid & sat_q;

  assign xfer_w = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
          len_d = len;
          // An empty job reports a zero result straight away.
          state_d = (len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (xfer_w) begin
          acc_d = sum_w;
          sat_d = sat_q | sat_w;
          cnt_d = cnt_q + CNT_W'(1);
          // len_q is non-zero here, so len_q-1 cannot underflow.
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/booth_product_acc.md
Name: booth_product_acc

Overview:
- Downstream consumer of the 8x8 sequential Booth multiplier.
- Takes a stream of signed 16-bit products over a valid/ready handshake.
- Accumulates a run-time-programmed count of products into a wider, saturating signed sum.
- Presents the sum on a valid/ready result port, forming the back half of a small dot-product / MAC datapath.

Parameters:
PROD_W, 16, signed product width (matches the multiplier out port)
ACC_W, 24, signed accumulator/result width; must be >= PROD_W+1
CNT_W, 8, width of the job length and of the internal product counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a job; sampled only in IDLE
len  in  CNT_W  number of products in the job (unsigned), captured on accepted start
in_valid  in  1  in_prod valid
in_ready  out  1  block accepts a product this cycle
in_prod  in  PROD_W  signed product from the multiplier
out_valid  out  1  out_sum/out_sat hold the finished job result
out_ready  in  1  consumer takes the result
out_sum  out  ACC_W  signed accumulated sum
out_sat  out  1  sticky: saturation occurred at least once in this job
busy  out  1  high in ACC and DONE

Behaviour:
- Reset: one clock with rst=1 forces state=IDLE, acc=0, cnt=0, len_q=0, sat=0. Outputs: in_ready=0, out_valid=0, out_sum=0, out_sat=0, busy=0. Reset mid-job aborts the job, discards partial sums and drops any pending result.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 with len!=0: capture len_q=len, clear acc/cnt/sat, go to ACC.
  - start=1 with len==0: clear acc/sat, go directly to DONE (result 0 one cycle after start).
  - start=0: stay in IDLE.
- ACC:
  - in_ready=1.
  - Transfer occurs when in_valid && in_ready.
  - On each transfer: acc <= sat(acc + sext(in_prod)) and cnt <= cnt+1.
  - When the transfer occurs with cnt==len_q-1, go to DONE.
  - No transfer: hold all state.
  - start is ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum=acc and out_sat=sat, both held stable while out_ready=0.
  - out_valid && out_ready: go to IDLE next cycle.
  - start is ignored in DONE, including in the cycle the result handshake completes; a new job needs start in IDLE.
- Latency: out_valid rises the cycle after the last accepted product. Throughput is one product per cycle.
- Arithmetic:
  - Compute the sum at ACC_W+1 bits.
  - Overflow clamps to 2^(ACC_W-1)-1; underflow clamps to -2^(ACC_W-1).
  - Either clamp sets sat, which stays set until the next start.
  - Accumulation continues from the clamped value.
- Counter: cnt never wraps, since the job ends at len_q (max 2^CNT_W-1).
- in_prod is never registered speculatively: only transferred values affect acc.

Decomposition:
- Shared package booth_pkg:
  - FSM state encoding (IDLE/ACC/DONE).
  - Default PROD_W/ACC_W/CNT_W constants shared with the multiplier.
  - Saturation limit constants derived from ACC_W.
- One sub-module is natural: sat_add (combinational signed add of sign-extended operand with clamp and overflow flag). It is reusable by future MAC stages.
- FSM, counter and handshake registers stay in booth_product_acc.

Test Plan:
- Reset then start with len=3; feed in_prod=805 (7*115) three times with in_valid held high -> out_valid high 1 cycle after the 3rd transfer, out_sum=2415, out_sat=0, busy low after out_ready.
- len=4, products 805, -805, -1000, 200 with in_valid gaps between them -> only 4 transfers counted, out_sum=-800; out_sum held stable across 3 cycles of out_ready=0.
- Override ACC_W=18; len=5, in_prod=32767 x5 -> out_sum=131071, out_sat=1. Then a new job with len=5, in_prod=-32768 x5 -> out_sum=-131072, out_sat=1. Then a job with len=1, in_prod=5 -> out_sat=0.
- start with len=0 -> out_valid the next cycle with out_sum=0, out_sat=0, no in_ready asserted.
- Mid-job reset: len=3, two transfers of 100, assert rst one cycle -> all outputs 0, state IDLE; a new job with len=1, in_prod=7 -> out_sum=7.
- start pulsed during ACC and in the DONE-handshake cycle -> ignored. The current job result is unchanged, and the block is in IDLE with busy=0 after the handshake.
